// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg: shared states, width defaults and frame helpers for the program loader.
package instr_mem_loader_pkg;

    localparam int INSTR_W_DEF = 16;
    localparam int ADDR_W_DEF  = 8;
    localparam bit BIG_ENDIAN  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_H,
        S_LEN_L,
        S_DATA_H,
        S_DATA_L,
        S_CHK,
        S_DONE,
        S_ERR
    } state_e;

    function automatic logic [15:0] pack_word(input logic [7:0] first, input logic [7:0] second);
        return BIG_ENDIAN ? {first, second} : {second, first};
    endfunction

    function automatic logic len_ok(input logic [15:0] n, input int aw);
        return (n != 16'd0) && (int'(n) <= (1 << aw));
    endfunction

endpackage

// File: rtl/instr_mem_loader_byte_pair_assembler.sv
// instr_mem_loader_byte_pair_assembler: pairs payload bytes into words and keeps the running XOR checksum.
module instr_mem_loader_byte_pair_assembler
    import instr_mem_loader_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               hi_en_i,
    input  logic               lo_en_i,
    input  logic [7:0]         byte_i,
    output logic               word_valid_o,
    output logic [INSTR_W-1:0] word_o,
    output logic [7:0]         chk_o
);

    logic [7:0]         hi_q;
    logic [7:0]         chk_q;
    logic [INSTR_W-1:0] word_q;
    logic               valid_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hi_q    <= '0;
            chk_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= lo_en_i;
            if (clear_i)
                chk_q <= '0;
            else if (hi_en_i || lo_en_i)
                chk_q <= chk_q ^ byte_i;
            if (hi_en_i)
                hi_q <= byte_i;
            if (lo_en_i)
                word_q <= INSTR_W'(pack_word(hi_q, byte_i));
        end
    end

    assign word_valid_o = valid_q;
    assign word_o       = word_q;
    assign chk_o        = chk_q;

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loads the MiniMIPS instruction memory from a framed, checksummed byte stream
// and holds the CPU until a load completes cleanly.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               load_err,
    output logic [ADDR_W:0]    words_loaded
);

    state_e            state_q;
    logic              byte_ready_q;
    logic              cpu_hold_q;
    logic              load_done_q;
    logic              load_err_q;
    logic [7:0]        len_hi_q;
    logic [15:0]       len_q;
    logic [ADDR_W:0]   words_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        chk;
    logic              accept;
    logic              can_start;
    logic [15:0]       len_in;

    assign accept    = byte_valid && byte_ready_q;
    assign can_start = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    assign len_in    = {len_hi_q, byte_data};

    instr_mem_loader_byte_pair_assembler #(.INSTR_W(INSTR_W)) u_asm (
        .clk_i        (clk),
        .reset_i      (reset),
        .clear_i      (can_start),
        .hi_en_i      (accept && state_q == S_DATA_H),
        .lo_en_i      (accept && state_q == S_DATA_L),
        .byte_i       (byte_data),
        .word_valid_o (wr_en),
        .word_o       (wr_data),
        .chk_o        (chk)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byte_ready_q <= 1'b0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            len_hi_q     <= '0;
            len_q        <= '0;
            words_q      <= '0;
            wr_addr_q    <= '0;
        end else begin
            // The count advances as each write retires, so it saturates at N by construction.
            if (wr_en)
                words_q <= words_q + (ADDR_W+1)'(1);
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (can_start) begin
                        state_q      <= S_LEN_H;
                        byte_ready_q <= 1'b1;
                        cpu_hold_q   <= 1'b1;
                        load_done_q  <= 1'b0;
                        load_err_q   <= 1'b0;
                        words_q      <= '0;
                        wr_addr_q    <= '0;
                    end
                end
                S_LEN_H: begin
                    if (accept) begin
                        len_hi_q <= byte_data;
                        state_q  <= S_LEN_L;
                    end
                end
                S_LEN_L: begin
                    if (accept) begin
                        len_q <= len_in;
                        if (len_ok(len_in, ADDR_W)) begin
                            state_q <= S_DATA_H;
                        end else begin
                            state_q      <= S_ERR;
                            byte_ready_q <= 1'b0;
                            load_err_q   <= 1'b1;
                        end
                    end
                end
                S_DATA_H: begin
                    if (accept)
                        state_q <= S_DATA_L;
                end
                S_DATA_L: begin
                    if (accept) begin
                        wr_addr_q <= words_q[ADDR_W-1:0];
                        state_q   <= (int'(words_q) + 1 == int'(len_q)) ? S_CHK : S_DATA_H;
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        byte_ready_q <= 1'b0;
                        if (byte_data == chk) begin
                            state_q     <= S_DONE;
                            cpu_hold_q  <= 1'b0;
                            load_done_q <= 1'b1;
                        end else begin
                            state_q    <= S_ERR;
                            load_err_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign byte_ready   = byte_ready_q;
    assign wr_addr      = wr_addr_q;
    assign cpu_hold     = cpu_hold_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: scoreboard bench; expected writes are queued as frames are built
// and matched against each wr_en strobe.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [8:0]  words_loaded;

    int errs = 0;
    int checks = 0;
    logic [7:0]  fr[$];
    logic [23:0] exp_q[$];
    logic [7:0]  xr;

    instr_mem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                check("spurious_wr_en", {24'd0, wr_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                check("wr_addr", {24'd0, wr_addr}, {24'd0, e[23:16]});
                check("wr_data", {16'd0, wr_data}, {16'd0, e[15:0]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int n = 0; n < 50 && !ok; n++) begin
            ok = byte_ready;
            tick();
        end
        if (!ok)
            check("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
        byte_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic frame_begin(input int n);
        fr = {};
        xr = 8'h00;
        fr.push_back(n[15:8]);
        fr.push_back(n[7:0]);
    endtask

    task automatic add_word(input logic [15:0] w, input logic [7:0] a);
        fr.push_back(w[15:8]);
        fr.push_back(w[7:0]);
        xr = xr ^ w[15:8] ^ w[7:0];
        exp_q.push_back({a, w});
    endtask

    task automatic send_frame(input int gap);
        foreach (fr[i]) send_byte(fr[i], gap);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        check({pfx, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        check({pfx, "_wr_addr"}, {24'd0, wr_addr}, 32'd0);
        check({pfx, "_wr_data"}, {16'd0, wr_data}, 32'd0);
        check({pfx, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
        check({pfx, "_load_done"}, {31'd0, load_done}, 32'd0);
        check({pfx, "_load_err"}, {31'd0, load_err}, 32'd0);
        check({pfx, "_words"}, {23'd0, words_loaded}, 32'd0);
    endtask

    task automatic check_end(input string pfx, input bit done, input int words);
        check({pfx, "_load_done"}, {31'd0, load_done}, {31'd0, done});
        check({pfx, "_load_err"}, {31'd0, load_err}, {31'd0, !done});
        check({pfx, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, !done});
        check({pfx, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        check({pfx, "_words"}, {23'd0, words_loaded}, words);
        repeat (3) tick();
        check({pfx, "_pending_writes"}, exp_q.size(), 32'd0);
    endtask

    task automatic nominal_frame(input logic [7:0] chk_flip);
        frame_begin(2);
        add_word(16'h1234, 8'd0);
        add_word(16'hABCD, 8'd1);
        fr.push_back(xr ^ chk_flip);
    endtask

    initial begin
        repeat (2) tick();
        check_reset_vals("rst");
        reset = 1'b0;
        tick();
        check("idle_ready", {31'd0, byte_ready}, 32'd0);

        // Nominal load, with a direct look at the one-cycle write latency.
        pulse_start();
        check("start_ready", {31'd0, byte_ready}, 32'd1);
        nominal_frame(8'h00);
        for (int i = 0; i < 4; i++) send_byte(fr[i], 0);
        check("lat_wr_en", {31'd0, wr_en}, 32'd1);
        check("lat_wr_addr", {24'd0, wr_addr}, 32'd0);
        check("lat_wr_data", {16'd0, wr_data}, 32'h1234);
        check("lat_ready", {31'd0, byte_ready}, 32'd1);
        for (int i = 4; i < fr.size(); i++) send_byte(fr[i], 0);
        check_end("nom", 1'b1, 2);

        // Bad checksum: writes still happen, then ERR.
        pulse_start();
        check("restart_done_clr", {31'd0, load_done}, 32'd0);
        check("restart_hold", {31'd0, cpu_hold}, 32'd1);
        nominal_frame(8'h01);
        check("badchk_byte", {24'd0, fr[6]}, 32'h41);
        send_frame(0);
        check_end("badchk", 1'b0, 2);

        // Zero and oversize lengths.
        pulse_start();
        check("err_clr", {31'd0, load_err}, 32'd0);
        frame_begin(0);
        send_frame(0);
        check_end("len0", 1'b0, 0);
        pulse_start();
        frame_begin(257);
        send_frame(0);
        check_end("len257", 1'b0, 0);

        // Stalled stream.
        pulse_start();
        nominal_frame(8'h00);
        send_frame(3);
        check_end("stall", 1'b1, 2);

        // Reset in the middle of a frame.
        pulse_start();
        frame_begin(2);
        add_word(16'h1234, 8'd0);
        send_frame(0);
        reset = 1'b1;
        tick();
        check_reset_vals("midrst");
        reset = 1'b0;
        tick();
        check("midrst_pending", exp_q.size(), 32'd0);
        pulse_start();
        nominal_frame(8'h00);
        send_frame(0);
        check_end("after_rst", 1'b1, 2);

        // Start during DATA_H is ignored; reload after DONE.
        pulse_start();
        nominal_frame(8'h00);
        send_byte(fr[0], 0);
        send_byte(fr[1], 0);
        pulse_start();
        check("ign_start_ready", {31'd0, byte_ready}, 32'd1);
        for (int i = 2; i < fr.size(); i++) send_byte(fr[i], 0);
        check_end("ign_start", 1'b1, 2);
        pulse_start();
        check("reload_done_clr", {31'd0, load_done}, 32'd0);
        check("reload_hold", {31'd0, cpu_hold}, 32'd1);
        frame_begin(1);
        add_word(16'hFF00, 8'd0);
        fr.push_back(xr);
        send_frame(0);
        check_end("reload", 1'b1, 1);

        // Full-depth load: last address is DEPTH-1.
        pulse_start();
        frame_begin(256);
        for (int i = 0; i < 256; i++) add_word({i[7:0], ~i[7:0]}, i[7:0]);
        fr.push_back(xr);
        send_frame(0);
        check_end("full", 1'b1, 256);
        check("full_last_addr", {24'd0, wr_addr}, 32'd255);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Program loader that writes the 16-bit instruction memory of the MiniMIPS core, which the core's fetch path reads.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words.
- Issues one write per word at incrementing addresses from 0, verifies an XOR checksum, and holds the processor until a load succeeds.
- Replaces file-based preloading for system-level runs.

Parameters:
- INSTR_W, 16, instruction word width.
- ADDR_W, 8, instruction memory address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: begin a load (honoured only in IDLE, DONE, ERR).
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts byte_data this cycle.
- wr_en  out  1  instruction memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  INSTR_W  write data.
- cpu_hold  out  1  high holds the processor PC at 0.
- load_done  out  1  high while in DONE.
- load_err  out  1  high while in ERR.
- words_loaded  out  ADDR_W+1  count of words written in the current load.

Behaviour:
- A byte is accepted when byte_valid and byte_ready are both high at a rising edge.
- Frame format: LEN_HI, LEN_LO (N, 16-bit word count), then 2*N payload bytes (high byte first), then CHK = XOR of all payload bytes. The length bytes are excluded from CHK.
- Reset values: byte_ready 0, wr_en 0, wr_addr 0, wr_data 0, cpu_hold 1, load_done 0, load_err 0, words_loaded 0. State goes to IDLE. Reset mid-load abandons the frame; memory already written stays as written.
- States: IDLE, LEN_H, LEN_L, DATA_H, DATA_L, CHK, DONE, ERR.
- IDLE: byte_ready 0; on start go to LEN_H and clear words_loaded, the checksum accumulator and the write address.
- LEN_H / LEN_L: byte_ready 1; capture N. After LEN_L:
  - N == 0 or N > DEPTH: go to ERR with no writes.
  - Otherwise go to DATA_H.
- DATA_H: byte_ready 1; latch the high byte and XOR it into the checksum.
- DATA_L: byte_ready 1; latch the low byte and XOR it into the checksum. Next cycle: wr_en=1 for exactly one cycle, wr_data = {hi, lo}, wr_addr = current index. Index and words_loaded increment after the write.
  - Write latency: 1 cycle after the low byte is accepted.
  - byte_ready stays 1 during the write cycle; a byte accepted then is the next DATA_H or the CHK byte (no bubble needed).
- After word N: go to CHK.
- CHK: byte_ready 1. On accept:
  - Byte equals the accumulator: go to DONE.
  - Otherwise: go to ERR.
- DONE: cpu_hold 0, load_done 1, byte_ready 0.
- ERR: cpu_hold 1, load_err 1, byte_ready 0.
- start in DONE or ERR begins a new load: cpu_hold returns to 1 in the same cycle it leaves DONE; load_done and load_err clear.
- start in any other state is ignored.
- Index wrap: wr_addr never wraps, since N ≤ DEPTH is enforced; with N == DEPTH the final address is DEPTH-1.
- words_loaded saturates at N and holds its value in DONE and ERR.
- byte_valid low stalls any state indefinitely; no timeout.

Decomposition:
- Shared package: loader state enum, INSTR_W/ADDR_W defaults, frame byte-order constant.
- One natural sub-module: byte_pair_assembler. It holds the hi/lo latch and the checksum accumulator, and outputs word_valid and word.

Test Plan:
- Nominal load: start, bytes 00 02 12 34 AB CD 40 -> wr_en at addr 0 data 0x1234, then addr 1 data 0xABCD; DONE, cpu_hold 0, words_loaded 2.
- Bad checksum: same frame with CHK 0x41 -> both writes occur; ERR, load_err 1, cpu_hold 1.
- Bad length: N=0 (00 00), and separately N=257 with ADDR_W=8 (01 01) -> ERR immediately, no wr_en, byte_ready 0 afterwards.
- Stalls: nominal frame with byte_valid deasserted for 3 cycles between every byte -> identical writes and final state; wr_en never repeats.
- Reset mid-frame: assert reset after 12 34 is accepted -> next cycle all outputs at reset values; a following full frame loads correctly from addr 0.
- Reload and ignored start: start pulsed in DATA_H is ignored; after DONE, start clears load_done and sets cpu_hold 1 the same cycle, and a second frame 00 01 FF 00 FF writes 0xFF00 at addr 0 and ends in DONE.
